motor_drive_arbiter: RTL and testbench

- Shares one motor_driver instance between NUM_REQ requesters, e.g. the theta and phi motors of one positioner.
- Arbitrates round-robin and latches the winner's pulse_period, pulse_len and dir. It then sequences the driver's start/ready handshake and reports per-requester completion or error.
- Presents sel so the parent can route the driver's phase outputs to the granted motor.

---
 rtl/motor_drive_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_motor_drive_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_drive_arbiter.sv
// Round-robin arbiter sharing one motor_driver between NUM_REQ requesters.
// Optional busy-phase watchdog enabled by defining MOTOR_ARB_WATCHDOG_EN.
module motor_drive_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int REG_W       = 16,
  parameter int WDOG_MARGIN = 64
) (
  input  logic                       clock_16mhz,
  input  logic                       reset_n,
  input  logic                       clock_1mhz,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*REG_W-1:0]   req_period,
  input  logic [NUM_REQ*REG_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0]         req_dir,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic [REG_W-1:0]           drv_pulse_period,
  output logic [REG_W-1:0]           drv_pulse_len,
  output logic                       drv_dir,
  output logic                       drv_start,
  input  logic                       drv_ready,
  output logic                       drv_reset,
  output logic [2:0]                 dbg_state
);
  localparam int SEL_W = $clog2(NUM_REQ);

  // Handshakes: req is a level held until the one-cycle ack; done/err are
  // one-cycle pulses. drv_start pulses only while drv_ready=1, the driver
  // drops drv_ready to accept and raises it again when finished.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARB        = 3'd1,
    S_START      = 3'd2,
    S_WAIT_LATCH = 3'd3,
    S_WAIT_READY = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic               busy_q, busy_d, start_q, start_d, dir_q, dir_d, flag_q, flag_d;
  logic [SEL_W-1:0]   sel_q, sel_d, ptr_q, ptr_d, gnt;
  logic [REG_W-1:0]   per_q, per_d, len_q, len_d, g_per, g_len;
  logic               g_dir, gnt_found;
  logic [1:0]         lat_cnt_q, lat_cnt_d;

`ifdef MOTOR_ARB_WATCHDOG_EN
  logic        clk1_q, rise_1m, rst_q, rst_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]  rst_cnt_q, rst_cnt_d;
  assign rise_1m   = clock_1mhz & ~clk1_q;
  assign drv_reset = rst_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clock_1mhz, WDOG_MARGIN[0]};
  assign drv_reset = 1'b0;
`endif

  // First set request strictly after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = SEL_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
    g_per = '0;
    g_len = '0;
    g_dir = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (SEL_W'(k) == gnt) begin
        g_per = req_period[k*REG_W +: REG_W];
        g_len = req_len[k*REG_W +: REG_W];
        g_dir = req_dir[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
    start_d   = 1'b0;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    per_d     = per_q;
    len_d     = len_q;
    dir_d     = dir_q;
    flag_d    = flag_q;
    lat_cnt_d = lat_cnt_q;
`ifdef MOTOR_ARB_WATCHDOG_EN
    rst_d     = 1'b0;
    wd_cnt_d  = wd_cnt_q;
    rst_cnt_d = rst_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MOTOR_ARB_WATCHDOG_EN
        if (|req && drv_ready) state_d = S_ARB;
`else
        if (|req) state_d = S_ARB;
`endif
      end
      S_ARB: begin
        if (!gnt_found) begin
          state_d = S_IDLE;
        end else begin
          sel_d      = gnt;
          per_d      = g_per;
          len_d      = g_len;
          dir_d      = g_dir;
          ack_d[gnt] = 1'b1;
          if (g_per <= REG_W'(3) || g_len == '0) begin
            flag_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            flag_d  = 1'b0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (drv_ready) begin
          start_d   = 1'b1;
          lat_cnt_d = '0;
          state_d   = S_WAIT_LATCH;
        end
      end
      S_WAIT_LATCH: begin
        if (!drv_ready) begin
          state_d = S_WAIT_READY;
`ifdef MOTOR_ARB_WATCHDOG_EN
          wd_cnt_d  = 32'(len_q) + 32'(WDOG_MARGIN);
          rst_cnt_d = '0;
`endif
        end else if (lat_cnt_q == 2'd3) begin
          flag_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      S_WAIT_READY: begin
`ifdef MOTOR_ARB_WATCHDOG_EN
        // Expiry holds drv_reset for two cycles before reporting the abort.
        if (rst_cnt_q == 2'd2) begin
          rst_d     = 1'b1;
          rst_cnt_d = 2'd1;
        end else if (rst_cnt_q == 2'd1) begin
          rst_cnt_d = '0;
          flag_d    = 1'b1;
          state_d   = S_DONE;
        end else if (drv_ready) begin
          state_d = S_DONE;
        end else if (rise_1m) begin
          if (wd_cnt_q <= 32'd1) begin
            rst_d     = 1'b1;
            rst_cnt_d = 2'd2;
          end else begin
            wd_cnt_d = wd_cnt_q - 32'd1;
          end
        end
`else
        if (drv_ready) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        done_d[sel_q] = 1'b1;
        err_d[sel_q]  = flag_q;
        ptr_d         = sel_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_16mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
      per_q     <= '0;
      len_q     <= '0;
      dir_q     <= 1'b0;
      flag_q    <= 1'b0;
      lat_cnt_q <= '0;
`ifdef MOTOR_ARB_WATCHDOG_EN
      clk1_q    <= 1'b0;
      rst_q     <= 1'b0;
      wd_cnt_q  <= '0;
      rst_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      per_q     <= per_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      flag_q    <= flag_d;
      lat_cnt_q <= lat_cnt_d;
`ifdef MOTOR_ARB_WATCHDOG_EN
      clk1_q    <= clock_1mhz;
      rst_q     <= rst_d;
      wd_cnt_q  <= wd_cnt_d;
      rst_cnt_q <= rst_cnt_d;
`endif
    end
  end

  assign ack              = ack_q;
  assign done             = done_q;
  assign err              = err_q;
  assign busy             = busy_q;
  assign sel              = sel_q;
  assign drv_pulse_period = per_q;
  assign drv_pulse_len    = len_q;
  assign drv_dir          = dir_q;
  assign drv_start        = start_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_motor_drive_arbiter.sv
// Directed bench for motor_drive_arbiter with a small motor_driver ready model.
`timescale 1ns/1ps
module tb_motor_drive_arbiter;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARB = 3'd1, S_START = 3'd2, S_WAIT_READY = 3'd4;

  logic        clock_16mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_1mhz = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] req_period = '0;
  logic [31:0] req_len = '0;
  logic [1:0]  req_dir = '0;
  logic [1:0]  ack, done, err;
  logic        busy, sel, drv_dir, drv_start, drv_reset;
  logic [15:0] drv_pulse_period, drv_pulse_len;
  logic        drv_ready = 1'b1;
  logic [2:0]  dbg_state;

  int n_checks = 0, n_pass = 0;
  int tick_n = 0, start_cnt = 0, rise_tick = 0, busy_cnt = 0, rst_seen = 0, edge_rises = 0;
  bit drv_auto = 1'b1;
  int drv_busy_len = 5;
  logic c1_prev = 1'b0;
  logic [1:0] ack_log[$];
  logic [1:0] exp_q[$];

  motor_drive_arbiter #(.NUM_REQ(2), .REG_W(16), .WDOG_MARGIN(4)) dut (
    .clock_16mhz(clock_16mhz), .reset_n(reset_n), .clock_1mhz(clock_1mhz),
    .req(req), .req_period(req_period), .req_len(req_len), .req_dir(req_dir),
    .ack(ack), .done(done), .err(err), .busy(busy), .sel(sel),
    .drv_pulse_period(drv_pulse_period), .drv_pulse_len(drv_pulse_len),
    .drv_dir(drv_dir), .drv_start(drv_start), .drv_ready(drv_ready),
    .drv_reset(drv_reset), .dbg_state(dbg_state)
  );

  always #31.25 clock_16mhz = ~clock_16mhz;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // One clock step: sample 1ns after the edge, then play requesters and driver.
  task automatic tick();
    if (clock_1mhz && !c1_prev) edge_rises++;
    c1_prev = clock_1mhz;
    @(posedge clock_16mhz);
    #1;
    tick_n++;
    clock_1mhz = ((tick_n % 16) < 8);
    if (ack != 2'b00) ack_log.push_back(ack);
    if (drv_start) start_cnt++;
    if (drv_reset) rst_seen++;
    req = req & ~ack;
    if (drv_auto) begin
      if (drv_start) begin
        drv_ready = 1'b0;
        busy_cnt  = drv_busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          drv_ready = 1'b1;
          rise_tick = tick_n;
        end
      end
    end
  endtask

  task automatic wait_done(output logic [1:0] d, output logic [1:0] e, output int t);
    d = 2'b00; e = 2'b00; t = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done != 2'b00) begin
        d = done; e = err; t = tick_n;
        return;
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (drv_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; drv_auto = 1'b1; drv_ready = 1'b1; busy_cnt = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++; if ({ack, done, err, busy, sel} !== 8'h00) $display("FAIL reset_flags: got %h want 00", {ack, done, err, busy, sel}); else n_pass++;
    n_checks++; if ({drv_pulse_period, drv_pulse_len, drv_dir, drv_start, drv_reset} !== 35'd0) $display("FAIL reset_drv: got %h want 0", {drv_pulse_period, drv_pulse_len, drv_dir, drv_start, drv_reset}); else n_pass++;
    n_checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
    do_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [1:0] d, e; int t, s0;
    req_period[15:0] = 16'd16; req_len[15:0] = 16'd10; req_dir[0] = 1'b1;
    req = 2'b01;
    tick();
    n_checks++; if (dbg_state !== S_ARB || busy !== 1'b1) $display("FAIL single_arb: got state %0d busy %b want %0d 1", dbg_state, busy, S_ARB); else n_pass++;
    tick();
    n_checks++; if (ack !== 2'b01) $display("FAIL single_ack: got %b want 01", ack); else n_pass++;
    n_checks++; if ({sel, drv_dir, drv_pulse_period, drv_pulse_len} !== {1'b0, 1'b1, 16'd16, 16'd10}) $display("FAIL single_fields: got %b %b %0d %0d want 0 1 16 10", sel, drv_dir, drv_pulse_period, drv_pulse_len); else n_pass++;
    s0 = start_cnt;
    tick();
    n_checks++; if (drv_start !== 1'b1 || ack !== 2'b00) $display("FAIL single_start: got start %b ack %b want 1 00", drv_start, ack); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b01 || e !== 2'b00) $display("FAIL single_done: got done %b err %b want 01 00", d, e); else n_pass++;
    n_checks++; if (t - rise_tick !== 2) $display("FAIL single_done_lat: got %0d want 2", t - rise_tick); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 1 || busy !== 1'b0) $display("FAIL single_starts: got %0d busy %b want 1 0", start_cnt - s0, busy); else n_pass++;
    tick();
    n_checks++; if (done !== 2'b00) $display("FAIL single_done_pulse: got %b want 00", done); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [1:0] d, e; int t;
    do_reset();
    ack_log.delete();
    req_dir = 2'b10; req_period[31:16] = 16'd20; req_len[31:16] = 16'd7;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    req = 2'b11;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b01 || sel !== 1'b0 || drv_dir !== 1'b0) $display("FAIL rr_first: got done %b sel %b dir %b want 01 0 0", d, sel, drv_dir); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b10 || sel !== 1'b1 || drv_dir !== 1'b1 || drv_pulse_period !== 16'd20) $display("FAIL rr_second: got done %b sel %b dir %b per %0d want 10 1 1 20", d, sel, drv_dir, drv_pulse_period); else n_pass++;
    req = 2'b11;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b01) $display("FAIL rr_third: got %b want 01", d); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (ack_log.size() !== 4) $display("FAIL rr_ack_count: got %0d want 4", ack_log.size()); else n_pass++;
    while (exp_q.size() > 0 && ack_log.size() > 0) begin
      logic [1:0] x, a;
      x = exp_q.pop_front(); a = ack_log.pop_front();
      n_checks++; if (a !== x) $display("FAIL rr_ack_order: got %b want %b", a, x); else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_invalid();
    int s0;
    s0 = start_cnt;
    req_period[31:16] = 16'd3;
    req = 2'b10;
    tick();
    n_checks++; if (busy !== 1'b1 || ack !== 2'b00) $display("FAIL inv_arb: got busy %b ack %b want 1 00", busy, ack); else n_pass++;
    tick();
    n_checks++; if (ack !== 2'b10 || busy !== 1'b1 || done !== 2'b00) $display("FAIL inv_ack: got ack %b busy %b done %b want 10 1 00", ack, busy, done); else n_pass++;
    tick();
    n_checks++; if (done !== 2'b10 || err !== 2'b10 || busy !== 1'b0) $display("FAIL inv_period: got done %b err %b busy %b want 10 10 0", done, err, busy); else n_pass++;
    req_period[31:16] = 16'd20;
    req_len[15:0] = 16'd0;
    req = 2'b01;
    tick(); tick();
    n_checks++; if (ack !== 2'b01) $display("FAIL inv_len_ack: got %b want 01", ack); else n_pass++;
    tick();
    n_checks++; if (done !== 2'b01 || err !== 2'b01) $display("FAIL inv_len: got done %b err %b want 01 01", done, err); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 0) $display("FAIL inv_no_start: got %0d want 0", start_cnt - s0); else n_pass++;
    req_len[15:0] = 16'd10;
  endtask

  task automatic test_not_ready();
    logic [1:0] d, e; int t, s0;
    drv_auto = 1'b0; drv_ready = 1'b0;
    req = 2'b01;
    tick(); tick();
    n_checks++; if (ack !== 2'b01) $display("FAIL nr_ack: got %b want 01", ack); else n_pass++;
    s0 = start_cnt;
    repeat (20) tick();
    n_checks++; if (start_cnt - s0 !== 0 || dbg_state !== S_START) $display("FAIL nr_hold: got starts %0d state %0d want 0 %0d", start_cnt - s0, dbg_state, S_START); else n_pass++;
    drv_ready = 1'b1; drv_auto = 1'b1; busy_cnt = 0;
    tick();
    n_checks++; if (drv_start !== 1'b1) $display("FAIL nr_start: got %b want 1", drv_start); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b01 || e !== 2'b00 || start_cnt - s0 !== 1) $display("FAIL nr_done: got done %b err %b starts %0d want 01 00 1", d, e, start_cnt - s0); else n_pass++;
  endtask

  task automatic test_latch_timeout();
    logic [1:0] d, e; int t, ts; bit ok;
    drv_auto = 1'b0; drv_ready = 1'b1;
    req = 2'b10;
    wait_start(ok);
    ts = tick_n;
    n_checks++; if (ok !== 1'b1) $display("FAIL lat_start: got %b want 1", ok); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b10 || e !== 2'b10 || t - ts !== 5) $display("FAIL lat_timeout: got done %b err %b lat %0d want 10 10 5", d, e, t - ts); else n_pass++;
    drv_auto = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] d, e; int t;
    req = 2'b01;
    wait_done(d, e, t);
    req = 2'b01;
    tick(); tick();
    n_checks++; if (ack !== 2'b01 || d !== 2'b01) $display("FAIL b2b_ack: got ack %b done %b want 01 01", ack, d); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b01 || e !== 2'b00) $display("FAIL b2b_done: got %b %b want 01 00", d, e); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] d, e, dseen; int t; bit ok;
    drv_auto = 1'b0; drv_ready = 1'b1;
    req = 2'b10;
    wait_start(ok);
    drv_ready = 1'b0;
    tick(); tick();
    n_checks++; if (dbg_state !== S_WAIT_READY || sel !== 1'b1) $display("FAIL mid_state: got %0d sel %b want %0d 1", dbg_state, sel, S_WAIT_READY); else n_pass++;
    #5 reset_n = 1'b0;
    #1;
    n_checks++; if ({ack, done, err, busy, sel, drv_dir, drv_start, dbg_state} !== 14'd0) $display("FAIL mid_reset_out: got %h want 0", {ack, done, err, busy, sel, drv_dir, drv_start, dbg_state}); else n_pass++;
    n_checks++; if ({drv_pulse_period, drv_pulse_len} !== 32'd0) $display("FAIL mid_reset_drv: got %h want 0", {drv_pulse_period, drv_pulse_len}); else n_pass++;
    tick();
    reset_n = 1'b1; drv_ready = 1'b1; drv_auto = 1'b1; busy_cnt = 0;
    dseen = 2'b00;
    repeat (5) begin tick(); dseen |= done; end
    n_checks++; if (dseen !== 2'b00) $display("FAIL mid_no_done: got %b want 00", dseen); else n_pass++;
    req = 2'b10;
    tick(); tick();
    n_checks++; if (ack !== 2'b10) $display("FAIL mid_regrant: got %b want 10", ack); else n_pass++;
    wait_done(d, e, t);
    n_checks++; if (d !== 2'b10 || e !== 2'b00) $display("FAIL mid_regrant_done: got %b %b want 10 00", d, e); else n_pass++;
  endtask

`ifdef MOTOR_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic [1:0] d, e; int t; bit ok, found;
    drv_auto = 1'b0; drv_ready = 1'b1;
    req = 2'b01;
    wait_start(ok);
    drv_ready = 1'b0;
    tick();
    edge_rises = 0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (drv_reset) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1 || edge_rises !== 14) $display("FAIL wd_expire: got found %b edges %0d want 1 14", found, edge_rises); else n_pass++;
    tick();
    n_checks++; if (drv_reset !== 1'b1) $display("FAIL wd_reset_len2: got %b want 1", drv_reset); else n_pass++;
    tick();
    n_checks++; if (drv_reset !== 1'b0 || done !== 2'b00) $display("FAIL wd_reset_end: got %b done %b want 0 00", drv_reset, done); else n_pass++;
    tick();
    n_checks++; if (done !== 2'b01 || err !== 2'b01) $display("FAIL wd_done_err: got %b %b want 01 01", done, err); else n_pass++;
    req = 2'b10;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || ack !== 2'b00) $display("FAIL wd_idle_gate: got busy %b ack %b want 0 00", busy, ack); else n_pass++;
    drv_ready = 1'b1; drv_auto = 1'b1; busy_cnt = 0;
    tick(); tick();
    n_checks++; if (ack !== 2'b10) $display("FAIL wd_regrant: got %b want 10", ack); else n_pass++;
    wait_done(d, e, t);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_invalid();
    test_not_ready();
    test_latch_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef MOTOR_ARB_WATCHDOG_EN
    test_watchdog();
`else
    n_checks++; if (rst_seen !== 0) $display("FAIL drv_reset_tied: got %0d high cycles want 0", rst_seen); else n_pass++;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
